fsm_flow_ctrl_param: RTL and testbench

Parametrised flow-control state machine for the multi-FIFO datapath. Generalises the 4-FIFO control FSM to NUM_FIFOS channels of configurable occupancy width. Watches per-FIFO occupancy counts and overflow strobes, and issues per-channel pausa/continua flow-control with hysteresis and sticky error reporting. Thresholds are loaded through an INIT phase.

---
 rtl/fsm_flow_ctrl_param_if.sv | 27 ++
 rtl/fsm_flow_ctrl_param.sv | 89 ++++++++
 tb/tb_fsm_flow_ctrl_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_flow_ctrl_param_if.sv
// fsm_flow_ctrl_param_if: occupancy/overflow inputs and flow-control outputs of the multi-FIFO controller
interface fsm_flow_ctrl_param_if #(
  parameter int NUM_FIFOS = 4,
  parameter int CW = 3
);
  logic init;
  logic [CW:0] umbral_af;
  logic [CW:0] umbral_ae;
  logic [NUM_FIFOS*(CW+1)-1:0] fifo_count;
  logic [NUM_FIFOS-1:0] fifo_overflow;
  logic [NUM_FIFOS-1:0] almost_full;
  logic [NUM_FIFOS-1:0] almost_empty;
  logic [NUM_FIFOS-1:0] pausa;
  logic [NUM_FIFOS-1:0] continua;
  logic [NUM_FIFOS-1:0] error_full;
  logic cfg_err;
  logic idle;
  logic [2:0] estado;
  modport master (
    output init, umbral_af, umbral_ae, fifo_count, fifo_overflow,
    input almost_full, almost_empty, pausa, continua, error_full, cfg_err, idle, estado
  );
  modport slave (
    input init, umbral_af, umbral_ae, fifo_count, fifo_overflow,
    output almost_full, almost_empty, pausa, continua, error_full, cfg_err, idle, estado
  );
endinterface

// File: rtl/fsm_flow_ctrl_param.sv
// fsm_flow_ctrl_param: per-channel pausa/continua flow control with hysteresis, INIT threshold load and sticky overflow errors
module fsm_flow_ctrl_param #(
  parameter int NUM_FIFOS = 4,
  parameter int CW = 3,
  parameter int AF_RST = 6,
  parameter int AE_RST = 1
) (
  input logic clk,
  input logic reset,
  fsm_flow_ctrl_param_if.slave bus
);
  localparam int W = CW + 1;
  localparam logic [W-1:0] FULL = W'(2 ** CW);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
  state_t state, next;
  logic [W-1:0] af_q, ae_q;
  logic [NUM_FIFOS-1:0] ge_af, le_ae, pausa_hys, continua_hys;
  logic [NUM_FIFOS-1:0] af_flag_q, ae_flag_q, pausa_q, continua_q, error_full_q;
  logic cfg_err_q, idle_q, cfg_ok, any_cnt, ovf, live;
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_ch
    // counts beyond 2^CW can only come from a misbehaving FIFO; treat them as full
    assign ge_af[i] = bus.fifo_count[i*W +: W] >= af_q || bus.fifo_count[i*W +: W] > FULL;
    assign le_ae[i] = bus.fifo_count[i*W +: W] <= ae_q;
  end
  assign cfg_ok = bus.umbral_ae < bus.umbral_af && bus.umbral_af <= FULL;
  assign any_cnt = |bus.fifo_count;
  assign ovf = |bus.fifo_overflow;
  assign pausa_hys = ge_af | (pausa_q & ~le_ae);
  assign continua_hys = pausa_q & ~pausa_hys;
  assign live = (state == S_IDLE || state == S_ACTIVE) && (next == S_IDLE || next == S_ACTIVE);
  always_comb begin
    next = state;
    case (state)
      S_RESET: next = S_INIT;
      S_INIT: next = (!bus.init && cfg_ok) ? S_IDLE : S_INIT;
      S_IDLE, S_ACTIVE: next = ovf ? S_ERROR : bus.init ? S_INIT : any_cnt ? S_ACTIVE : S_IDLE;
      default: next = S_ERROR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_RESET;
      af_q <= W'(AF_RST);
      ae_q <= W'(AE_RST);
      af_flag_q <= '0;
      ae_flag_q <= '0;
      pausa_q <= '0;
      continua_q <= '0;
      error_full_q <= '0;
      cfg_err_q <= 1'b0;
      idle_q <= 1'b0;
    end else begin
      state <= next;
      af_flag_q <= ge_af;
      ae_flag_q <= le_ae;
      idle_q <= next == S_IDLE;
      if (state == S_INIT) begin
        cfg_err_q <= !cfg_ok;
        if (cfg_ok) begin
          af_q <= bus.umbral_af;
          ae_q <= bus.umbral_ae;
        end
      end
      // leaving the live states any other way than to ERROR drops pausa silently
      if (next == S_ERROR) begin
        pausa_q <= '1;
        continua_q <= '0;
        error_full_q <= error_full_q | bus.fifo_overflow;
      end else begin
        pausa_q <= live ? pausa_hys : '0;
        continua_q <= live ? continua_hys : '0;
      end
    end
  end
  assign bus.almost_full = af_flag_q;
  assign bus.almost_empty = ae_flag_q;
  assign bus.pausa = pausa_q;
  assign bus.continua = continua_q;
  assign bus.error_full = error_full_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.idle = idle_q;
  assign bus.estado = state;
endmodule

// File: tb/tb_fsm_flow_ctrl_param.sv
// tb_fsm_flow_ctrl_param: directed bench with a rule-level model for a 4x3 and an 8x4 instance
module tb_fsm_flow_ctrl_param;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  bit go = 1'b0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  fsm_flow_ctrl_param_if #(.NUM_FIFOS(4), .CW(3)) ba ();
  fsm_flow_ctrl_param_if #(.NUM_FIFOS(8), .CW(4)) bb ();
  fsm_flow_ctrl_param #(.NUM_FIFOS(4), .CW(3)) dut_a (.clk(clk), .reset(rst_a), .bus(ba));
  fsm_flow_ctrl_param #(.NUM_FIFOS(8), .CW(4)) dut_b (.clk(clk), .reset(rst_b), .bus(bb));
  int ms[2], maf[2], mae[2], e_est[2];
  bit [7:0] e_af[2], e_ae[2], e_p[2], e_c[2], e_ef[2];
  bit e_cfg[2], e_idle[2];
  int ca[8], cb[8];
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  // Rule-level model: one step per rising edge from the inputs applied before it
  task automatic model(input int k, input int n, input int full, input bit rn, input bit ini,
                       input int af, input int ae, input int c[8], input bit [7:0] ov);
    int cur;
    bit ok, anyc;
    if (!rn) begin
      ms[k] = 0; maf[k] = 6; mae[k] = 1; e_est[k] = 0;
      e_af[k] = 0; e_ae[k] = 0; e_p[k] = 0; e_c[k] = 0; e_ef[k] = 0; e_cfg[k] = 0; e_idle[k] = 0;
    end else begin
      cur = ms[k];
      anyc = 0;
      for (int j = 0; j < n; j++) begin
        e_af[k][j] = c[j] >= maf[k] || c[j] > full;
        e_ae[k][j] = c[j] <= mae[k];
        anyc |= c[j] != 0;
      end
      if (cur == 0) ms[k] = 1;
      else if (cur == 1) begin
        ok = ae < af && af <= full;
        e_cfg[k] = !ok;
        if (ok) begin maf[k] = af; mae[k] = ae; end
        if (!ini && ok) ms[k] = 2;
      end else if (cur != 4) ms[k] = ov != 0 ? 4 : ini ? 1 : anyc ? 3 : 2;
      if (ms[k] == 4) begin
        e_p[k] = 8'((1 << n) - 1);
        e_c[k] = 0;
        e_ef[k] |= ov;
      end else if (cur >= 2 && ms[k] >= 2) begin
        for (int j = 0; j < n; j++) begin
          bit np;
          np = (c[j] >= maf[k] || c[j] > full) ? 1'b1 : (c[j] <= mae[k]) ? 1'b0 : e_p[k][j];
          e_c[k][j] = e_p[k][j] && !np;
          e_p[k][j] = np;
        end
      end else begin
        e_p[k] = 0;
        e_c[k] = 0;
      end
      e_idle[k] = ms[k] == 2;
      e_est[k] = ms[k];
    end
  endtask
  always @(posedge clk) begin
    for (int j = 0; j < 8; j++) ca[j] = 0;
    for (int j = 0; j < 4; j++) ca[j] = int'(ba.fifo_count[j*4 +: 4]);
    for (int j = 0; j < 8; j++) cb[j] = int'(bb.fifo_count[j*5 +: 5]);
    model(0, 4, 8, rst_a, ba.init, int'(ba.umbral_af), int'(ba.umbral_ae), ca, {4'b0, ba.fifo_overflow});
    model(1, 8, 16, rst_b, bb.init, int'(bb.umbral_af), int'(bb.umbral_ae), cb, bb.fifo_overflow);
  end
  always @(negedge clk) if (go) begin
    chk("a_estado", 32'(ba.estado), 32'(e_est[0]));
    chk("a_idle", 32'(ba.idle), 32'(e_idle[0]));
    chk("a_cfg_err", 32'(ba.cfg_err), 32'(e_cfg[0]));
    chk("a_almost_full", 32'(ba.almost_full), 32'(e_af[0][3:0]));
    chk("a_almost_empty", 32'(ba.almost_empty), 32'(e_ae[0][3:0]));
    chk("a_pausa", 32'(ba.pausa), 32'(e_p[0][3:0]));
    chk("a_continua", 32'(ba.continua), 32'(e_c[0][3:0]));
    chk("a_error_full", 32'(ba.error_full), 32'(e_ef[0][3:0]));
    chk("b_estado", 32'(bb.estado), 32'(e_est[1]));
    chk("b_idle", 32'(bb.idle), 32'(e_idle[1]));
    chk("b_cfg_err", 32'(bb.cfg_err), 32'(e_cfg[1]));
    chk("b_almost_full", 32'(bb.almost_full), 32'(e_af[1]));
    chk("b_almost_empty", 32'(bb.almost_empty), 32'(e_ae[1]));
    chk("b_pausa", 32'(bb.pausa), 32'(e_p[1]));
    chk("b_continua", 32'(bb.continua), 32'(e_c[1]));
    chk("b_error_full", 32'(bb.error_full), 32'(e_ef[1]));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cnt_a(input int j, input int v);
    ba.fifo_count[j*4 +: 4] = 4'(v);
  endtask
  task automatic cnt_b(input int j, input int v);
    bb.fifo_count[j*5 +: 5] = 5'(v);
  endtask
  function automatic int ramp(input int t);
    return t < 0 ? 0 : t <= 14 ? t : (28 - t > 0 ? 28 - t : 0);
  endfunction
  initial begin
    rst_a = 0; rst_b = 0;
    ba.init = 0; ba.umbral_af = 0; ba.umbral_ae = 0; ba.fifo_count = '0; ba.fifo_overflow = '0;
    bb.init = 0; bb.umbral_af = 0; bb.umbral_ae = 0; bb.fifo_count = '0; bb.fifo_overflow = '0;
    tick();
    go = 1;
    tick();
    chk("rst_estado", 32'(ba.estado), 0);
    chk("rst_pausa", 32'(ba.pausa), 0);
    rst_a = 1; ba.init = 1; ba.umbral_af = 6; ba.umbral_ae = 1;
    tick();
    chk("reset_to_init", 32'(ba.estado), 1);
    tick();
    ba.init = 0;
    tick();
    chk("init_to_idle", 32'(ba.estado), 2);
    chk("idle_flag", 32'(ba.idle), 1);
    chk("model_idle_pin", 32'(e_est[0]), 2);
    for (int c = 1; c <= 7; c++) begin
      cnt_a(0, c);
      tick();
      if (c == 5) chk("pausa_below_af", 32'(ba.pausa), 0);
      if (c == 6) begin
        chk("pausa_at_af", 32'(ba.pausa), 1);
        chk("almost_full_at_af", 32'(ba.almost_full), 1);
        chk("active_state", 32'(ba.estado), 3);
      end
    end
    for (int c = 6; c >= 2; c--) begin
      cnt_a(0, c);
      tick();
    end
    chk("pausa_hold", 32'(ba.pausa), 1);
    cnt_a(0, 1);
    tick();
    chk("pausa_clear", 32'(ba.pausa), 0);
    chk("continua_pulse", 32'(ba.continua), 1);
    tick();
    chk("continua_once", 32'(ba.continua), 0);
    cnt_a(0, 0);
    tick();
    chk("back_to_idle", 32'(ba.estado), 2);
    ba.init = 1; ba.umbral_af = 3; ba.umbral_ae = 5; cnt_a(0, 4);
    tick();
    chk("idle_to_init", 32'(ba.estado), 1);
    tick();
    chk("cfg_err_set", 32'(ba.cfg_err), 1);
    chk("af_kept", 32'(ba.almost_full), 0);
    ba.init = 0; ba.umbral_af = 5; ba.umbral_ae = 3;
    tick();
    chk("cfg_err_clear", 32'(ba.cfg_err), 0);
    chk("cfg_to_idle", 32'(ba.estado), 2);
    tick();
    cnt_a(0, 5); cnt_a(1, 12);
    tick();
    chk("pausa_new_af_and_overfull", 32'(ba.pausa), 4'b0011);
    ba.fifo_overflow = 4'b0100;
    tick();
    chk("err_state", 32'(ba.estado), 4);
    chk("err_full_first", 32'(ba.error_full), 4'b0100);
    chk("err_pausa_all", 32'(ba.pausa), 4'b1111);
    chk("model_err_pin", 32'(e_ef[0]), 4'b0100);
    ba.fifo_overflow = 0;
    tick();
    ba.fifo_overflow = 4'b0001;
    tick();
    chk("err_full_sticky", 32'(ba.error_full), 4'b0101);
    ba.fifo_overflow = 0; ba.init = 1;
    tick();
    chk("err_ignores_init", 32'(ba.estado), 4);
    rst_a = 0; ba.init = 0;
    tick();
    chk("reset_from_err", 32'(ba.estado), 0);
    chk("reset_clears_err", 32'(ba.error_full), 0);
    rst_a = 1; ba.umbral_af = 6; ba.umbral_ae = 1; cnt_a(0, 0); cnt_a(1, 0);
    tick();
    tick();
    chk("reinit_idle", 32'(ba.estado), 2);
    ba.init = 1; ba.fifo_overflow = 4'b1000;
    tick();
    chk("ovf_beats_init", 32'(ba.estado), 4);
    chk("ovf_beats_init_ef", 32'(ba.error_full), 4'b1000);
    ba.init = 0; ba.fifo_overflow = 4'b0011;
    tick();
    chk("multi_ovf", 32'(ba.error_full), 4'b1011);
    ba.fifo_overflow = 0;
    tick();
    rst_a = 0;
    tick();
    chk("mid_err_reset_est", 32'(ba.estado), 0);
    chk("mid_err_reset_ef", 32'(ba.error_full), 0);
    chk("mid_err_reset_pausa", 32'(ba.pausa), 0);
    rst_b = 1; bb.init = 1; bb.umbral_af = 12; bb.umbral_ae = 2;
    tick();
    bb.init = 0;
    tick();
    chk("b_idle_after_init", 32'(bb.estado), 2);
    for (int t = 0; t <= 36; t++) begin
      cnt_b(0, ramp(t));
      cnt_b(7, ramp(t - 6));
      tick();
      if (t == 12) chk("b_pausa_ch0", 32'(bb.pausa), 8'h01);
      if (t == 18) chk("b_pausa_both", 32'(bb.pausa), 8'h81);
      if (t == 26) begin
        chk("b_pausa_ch7_only", 32'(bb.pausa), 8'h80);
        chk("b_continua_ch0", 32'(bb.continua), 8'h01);
      end
      if (t == 32) begin
        chk("b_pausa_none", 32'(bb.pausa), 8'h00);
        chk("b_continua_ch7", 32'(bb.continua), 8'h80);
      end
    end
    tick();
    chk("b_back_idle", 32'(bb.estado), 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
